// File: rtl/types_pkg.sv
// Shared type definitions for the user-facing interface logic.
// Holds the interface FSM state and the input holder fill state.
package types_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        I_IDLE    = 2'd0,
        I_LOAD    = 2'd1,
        I_ENCRYPT = 2'd2,
        I_OUTPUT  = 2'd3
    } interface_state_t;

    typedef enum logic [1:0] {
        IH_EMPTY   = 2'd0,
        IH_PENDING = 2'd1,
        IH_FULL    = 2'd2
    } input_holder_state_t;

endpackage

// File: rtl/input_holder_if.sv
// Byte handshake between the input holder and the encryption block.
// The holder drives the byte and its strobe; the consumer drives ready.
interface input_holder_if;
    import types_pkg::*;

    logic [BYTE_W-1:0] data_out;
    logic              data_out_pulse;
    logic              enc_ready;

    modport master (
        output data_out,
        output data_out_pulse,
        input  enc_ready
    );

    modport slave (
        input  data_out,
        input  data_out_pulse,
        output enc_ready
    );

endinterface

// File: rtl/sync_rise_detect.sv
// Synchronizes an asynchronous level and flags its rising edge.
// rise_o is high for one cycle per synchronized low-to-high transition.
module sync_rise_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_i};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/input_holder.sv
// Captures user bytes from slow asynchronous strobes into a small buffer
// and hands each one to the encryption block as a single-cycle pulse.
module input_holder
    import types_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [BYTE_W-1:0]   data_in,
    input  logic                data_valid_in,
    input  interface_state_t    interface_state,
    input_holder_if.master      enc_if,
    output input_holder_state_t input_holder_state_out,
    output logic                overflow_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     rd_ptr_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [BYTE_W-1:0] dout_q;
    logic [BYTE_W-1:0] dout_d;
    logic              pulse_q;
    logic              pulse_d;
    logic              ovf_q;
    logic              ovf_d;

    logic rise;
    logic idle;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    sync_rise_detect #(
        .STAGES (SYNC_STAGES)
    ) u_dv_sync (
        .clk     (clk),
        .nrst    (nrst),
        .async_i (data_valid_in),
        .rise_o  (rise)
    );

    // A pop frees a slot on the same edge, so a full buffer still accepts.
    always_comb begin
        idle  = (interface_state == I_IDLE);
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        pop   = !idle && !empty && enc_if.enc_ready && !pulse_q;
        push  = rise && !idle && (!full || pop);
        drop  = rise && !idle && full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        pulse_d  = pop;
        dout_d   = pop ? mem_q[rd_ptr_q] : dout_q;
        if (idle) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            pulse_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            pulse_q  <= pulse_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_comb begin
        unique case (1'b1)
            empty:   input_holder_state_out = IH_EMPTY;
            full:    input_holder_state_out = IH_FULL;
            default: input_holder_state_out = IH_PENDING;
        endcase
    end

    assign enc_if.data_out       = dout_q;
    assign enc_if.data_out_pulse = pulse_q;
    assign overflow_out          = ovf_q;

endmodule

// File: tb/tb_input_holder.sv
// Self-checking bench for input_holder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_input_holder;
    import types_pkg::*;

    localparam int DEPTH = 2;
    localparam int SYNC  = 2;

    logic                clk  = 1'b0;
    logic                nrst = 1'b0;
    logic [7:0]          data_in = 8'h00;
    logic                dv = 1'b0;
    interface_state_t    ist = I_ENCRYPT;
    input_holder_state_t hs;
    logic                ovf;

    input_holder_if bus ();

    always #5 clk = ~clk;

    input_holder #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk                    (clk),
        .nrst                   (nrst),
        .data_in                (data_in),
        .data_valid_in          (dv),
        .interface_state        (ist),
        .enc_if                 (bus.master),
        .input_holder_state_out (hs),
        .overflow_out           (ovf)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [7:0] obs_q[$];
    int         obs_t[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.data_out_pulse === 1'b1) begin
            obs_q.push_back(bus.data_out);
            obs_t.push_back(cyc);
        end
    end

    // Reference model: a byte lands SYNC edges after dv is first sampled
    // high; pops need a ready consumer and no pulse in the previous cycle.
    logic [7:0]          mq[$];
    logic                m_pulse = 1'b0;
    logic [7:0]          m_dout  = 8'h00;
    logic                m_ovf   = 1'b0;
    logic [SYNC+1:0]     hist    = '0;
    logic                m_rise;
    logic                m_pop;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mq.delete();
            m_pulse = 1'b0;
            m_dout  = 8'h00;
            m_ovf   = 1'b0;
            hist    = '0;
        end else begin
            hist   = {hist[SYNC:0], dv};
            m_rise = hist[SYNC] & ~hist[SYNC+1];
            if (ist == I_IDLE) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_pulse = 1'b0;
            end else begin
                m_pop   = (mq.size() > 0) && bus.enc_ready && !m_pulse;
                m_pulse = m_pop;
                if (m_pop) m_dout = mq.pop_front();
                if (m_rise) begin
                    if (mq.size() < DEPTH) mq.push_back(data_in);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic input_holder_state_t m_state();
        if (mq.size() == 0) return IH_EMPTY;
        if (mq.size() == DEPTH) return IH_FULL;
        return IH_PENDING;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_obs();
        #1;
        obs_q.delete();
        obs_t.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        data_in = b;
        tick();
        dv = 1'b1;
        tick(hi);
        dv = 1'b0;
        tick(lo);
    endtask

    task automatic do_idle();
        ist = I_IDLE;
        tick();
        ist = I_ENCRYPT;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick(2);
        n_cmp++;
        if (bus.data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_dout: got %0h want 0", bus.data_out);
        end
        n_cmp++;
        if (bus.data_out_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulse: got %0b want 0", bus.data_out_pulse);
        end
        n_cmp++;
        if (hs !== IH_EMPTY) begin
            n_err++;
            $display("FAIL reset_state: got %0d want %0d", hs, IH_EMPTY);
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %0b want 0", ovf);
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        input_holder_state_t es;
        ist = I_ENCRYPT;
        bus.enc_ready = 1'b1;
        data_in = 8'hA5;
        tick();
        clr_obs();
        dv = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_cmp++;
            if (bus.data_out_pulse !== (i == 4)) begin
                n_err++;
                $display("FAIL single_pulse[%0d]: got %0b want %0b",
                         i, bus.data_out_pulse, (i == 4));
            end
            es = (i == 3) ? IH_PENDING : IH_EMPTY;
            n_cmp++;
            if (hs !== es) begin
                n_err++;
                $display("FAIL single_state[%0d]: got %0d want %0d", i, hs, es);
            end
            if (i == 4) begin
                n_cmp++;
                if (bus.data_out !== 8'hA5) begin
                    n_err++;
                    $display("FAIL single_dout: got %0h want a5", bus.data_out);
                end
            end
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL single_ovf: got %0b want 0", ovf);
        end
        dv = 1'b0;
        tick(3);
    endtask

    task automatic test_overflow();
        ist = I_ENCRYPT;
        bus.enc_ready = 1'b0;
        send_byte(8'h11, 4, 4);
        send_byte(8'h22, 4, 4);
        n_cmp++;
        if (hs !== IH_FULL || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_full2: got state %0d ovf %0b want %0d 0",
                     hs, ovf, IH_FULL);
        end
        send_byte(8'h33, 4, 4);
        n_cmp++;
        if (hs !== IH_FULL || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: got state %0d ovf %0b want %0d 1",
                     hs, ovf, IH_FULL);
        end
        clr_obs();
        bus.enc_ready = 1'b1;
        tick(10);
        #1;
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_err++;
            $display("FAIL ovf_npulse: got %0d want 2", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0] !== 8'h11 || obs_q[1] !== 8'h22) begin
                n_err++;
                $display("FAIL ovf_order: got %0h %0h want 11 22",
                         obs_q[0], obs_q[1]);
            end
            n_cmp++;
            if (obs_t[1] - obs_t[0] < 2) begin
                n_err++;
                $display("FAIL ovf_spacing: got %0d want >=2",
                         obs_t[1] - obs_t[0]);
            end
        end
        n_cmp++;
        if (hs !== IH_EMPTY || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drain: got state %0d ovf %0b want %0d 1",
                     hs, ovf, IH_EMPTY);
        end
    endtask

    task automatic test_simul_pop();
        do_idle();
        bus.enc_ready = 1'b0;
        send_byte(8'h61, 4, 4);
        send_byte(8'h62, 4, 4);
        data_in = 8'h63;
        tick();
        clr_obs();
        dv = 1'b1;
        tick(2);
        n_cmp++;
        if (hs !== IH_FULL) begin
            n_err++;
            $display("FAIL simul_prefull: got %0d want %0d", hs, IH_FULL);
        end
        bus.enc_ready = 1'b1;
        tick(3);
        dv = 1'b0;
        tick(8);
        #1;
        n_cmp++;
        if (obs_q.size() != 3) begin
            n_err++;
            $display("FAIL simul_npulse: got %0d want 3", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0] !== 8'h61 || obs_q[1] !== 8'h62 || obs_q[2] !== 8'h63) begin
                n_err++;
                $display("FAIL simul_order: got %0h %0h %0h want 61 62 63",
                         obs_q[0], obs_q[1], obs_q[2]);
            end
        end
        n_cmp++;
        if (ovf !== 1'b0 || hs !== IH_EMPTY) begin
            n_err++;
            $display("FAIL simul_end: got ovf %0b state %0d want 0 %0d",
                     ovf, hs, IH_EMPTY);
        end
    endtask

    task automatic test_idle_flush();
        bus.enc_ready = 1'b0;
        send_byte(8'h44, 4, 4);
        send_byte(8'h55, 4, 4);
        send_byte(8'h66, 4, 4);
        n_cmp++;
        if (hs !== IH_FULL || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre: got state %0d ovf %0b want %0d 1",
                     hs, ovf, IH_FULL);
        end
        do_idle();
        n_cmp++;
        if (hs !== IH_EMPTY || ovf !== 1'b0 || bus.data_out_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: got state %0d ovf %0b pulse %0b want %0d 0 0",
                     hs, ovf, bus.data_out_pulse, IH_EMPTY);
        end
        clr_obs();
        bus.enc_ready = 1'b1;
        tick(6);
        #1;
        n_cmp++;
        if (obs_q.size() != 0 || bus.data_out !== 8'h63) begin
            n_err++;
            $display("FAIL flush_nopulse: got %0d pulses dout %0h want 0 63",
                     obs_q.size(), bus.data_out);
        end
        ist = I_IDLE;
        send_byte(8'h77, 4, 4);
        ist = I_ENCRYPT;
        tick(6);
        #1;
        n_cmp++;
        if (obs_q.size() != 0 || hs !== IH_EMPTY || bus.data_out !== 8'h63) begin
            n_err++;
            $display("FAIL flush_idle_strobe: got %0d pulses state %0d dout %0h want 0 %0d 63",
                     obs_q.size(), hs, bus.data_out, IH_EMPTY);
        end
    endtask

    task automatic test_reset_mid_pulse();
        bus.enc_ready = 1'b1;
        data_in = 8'h99;
        tick();
        dv = 1'b1;
        tick(4);
        n_cmp++;
        if (bus.data_out_pulse !== 1'b1 || bus.data_out !== 8'h99) begin
            n_err++;
            $display("FAIL rst_pulse_pre: got pulse %0b dout %0h want 1 99",
                     bus.data_out_pulse, bus.data_out);
        end
        nrst = 1'b0;
        dv = 1'b0;
        #1;
        n_cmp++;
        if (bus.data_out_pulse !== 1'b0 || bus.data_out !== 8'h00) begin
            n_err++;
            $display("FAIL rst_pulse_kill: got pulse %0b dout %0h want 0 0",
                     bus.data_out_pulse, bus.data_out);
        end
        tick();
        nrst = 1'b1;
        clr_obs();
        tick(8);
        #1;
        n_cmp++;
        if (obs_q.size() != 0 || hs !== IH_EMPTY) begin
            n_err++;
            $display("FAIL rst_stale: got %0d pulses state %0d want 0 %0d",
                     obs_q.size(), hs, IH_EMPTY);
        end
    endtask

    task automatic test_long_strobe();
        bus.enc_ready = 1'b1;
        clr_obs();
        send_byte(8'h7E, 50, 6);
        #1;
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_err++;
            $display("FAIL long_npulse: got %0d want 1", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0] !== 8'h7E) begin
                n_err++;
                $display("FAIL long_dout: got %0h want 7e", obs_q[0]);
            end
        end
    endtask

    task automatic test_random();
        int  hi_cnt = 0;
        bit  staged = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            n_cmp++;
            if (bus.data_out_pulse !== m_pulse) begin
                n_err++;
                $display("FAIL rnd_pulse[%0d]: got %0b want %0b",
                         c, bus.data_out_pulse, m_pulse);
            end
            n_cmp++;
            if (bus.data_out !== m_dout) begin
                n_err++;
                $display("FAIL rnd_dout[%0d]: got %0h want %0h",
                         c, bus.data_out, m_dout);
            end
            n_cmp++;
            if (hs !== m_state()) begin
                n_err++;
                $display("FAIL rnd_state[%0d]: got %0d want %0d",
                         c, hs, m_state());
            end
            n_cmp++;
            if (ovf !== m_ovf) begin
                n_err++;
                $display("FAIL rnd_ovf[%0d]: got %0b want %0b", c, ovf, m_ovf);
            end
            if (dv) begin
                hi_cnt++;
                if (hi_cnt >= 3 && ($urandom % 3) == 0) begin
                    dv = 1'b0;
                    staged = 1'b0;
                end
            end else if (!staged) begin
                data_in = 8'($urandom);
                staged = 1'b1;
            end else if (($urandom % 2) == 0) begin
                dv = 1'b1;
                hi_cnt = 0;
            end
            bus.enc_ready = (($urandom % 3) == 0);
            ist = (($urandom % 50) == 0) ? I_IDLE : I_ENCRYPT;
        end
        dv = 1'b0;
        ist = I_ENCRYPT;
    endtask

    initial begin
        bus.enc_ready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_simul_pop();
        test_idle_flush();
        test_reset_mid_pulse();
        test_long_strobe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
